// File: rtl/slice_sequencer.sv
// Slice sequencer: loads each input file, walks its lines and streams the slices over valid/ready.
// Optional build macro SLICE_PARITY_EN adds registered per-row parity on slice_parity.
`timescale 1ns/1ps
module slice_sequencer #(
  parameter int NUM_FILES = 1,
  parameter int WIDTH     = 25,
  parameter int LINES     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             read_file,
  output logic [9:0]       file_index,
  output logic [5:0]       line_index,
  input  logic [WIDTH-1:0] data_in,
  output logic             slice_valid,
  input  logic             slice_ready,
  output logic [WIDTH-1:0] slice_data,
  output logic [5:0]       slice_line,
  output logic             slice_last,
  output logic [4:0]       slice_parity,
  output logic             busy,
  output logic             done
);

  localparam logic [9:0] LAST_FILE = 10'(NUM_FILES - 1);
  localparam logic [5:0] LAST_LINE = 6'(LINES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, STREAM, DONE} state_t;

  state_t state, state_nxt;
  logic   hs, file_end, final_file, capture, launch;

  assign hs         = slice_valid && slice_ready;
  assign final_file = (file_index == LAST_FILE);
  assign file_end   = (state == STREAM) && hs && slice_last;
  assign launch     = (state == IDLE) && start;
  // FETCH primes the output register; later lines are captured on the handshake edge.
  assign capture    = (state == FETCH) || ((state == STREAM) && hs && !slice_last);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM:  if (file_end) state_nxt = final_file ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_file   <= 1'b0;
      done        <= 1'b0;
      file_index  <= '0;
      line_index  <= '0;
      slice_valid <= 1'b0;
    end else begin
      read_file <= launch || (file_end && !final_file);
      done      <= file_end && final_file;
      if (launch) begin
        file_index <= '0;
        line_index <= '0;
      end else if (file_end && !final_file) begin
        file_index <= file_index + 10'd1;
      end
      if (capture) begin
        line_index  <= line_index + 6'd1;
        slice_valid <= 1'b1;
      end else if (file_end) begin
        slice_valid <= 1'b0;
      end
    end
  end

  // Slice output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slice_data <= '0;
      slice_line <= '0;
      slice_last <= 1'b0;
    end else if (capture) begin
      slice_data <= data_in;
      slice_line <= line_index;
      slice_last <= (line_index == LAST_LINE);
    end
  end

`ifdef SLICE_PARITY_EN
  function automatic logic [4:0] row_parity(input logic [WIDTH-1:0] d);
    logic [4:0] p;
    for (int i = 0; i < 5; i++) p[i] = ^d[5*i +: 5];
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         slice_parity <= '0;
    else if (capture) slice_parity <= row_parity(data_in);
  end
`else
  assign slice_parity = 5'b0;
`endif

endmodule
